// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, instruction fields and sequencer state encoding shared by the
// sequencer and the compute-unit decoder.
package cu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_LOAD = 4'b1001;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_NOT  = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b1111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// cu_sequencer_if: instruction handshake between the sequencer (master) and the
// compute unit (slave).
interface cu_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        cu_ready;

    modport master (output instr, output instr_valid, input cu_ready);
    modport slave  (input instr, input instr_valid, output cu_ready);
endinterface

// File: rtl/cu_sequencer.sv
// cu_sequencer: loads 16-bit instructions byte-serially into a flop store and
// replays them to the compute unit, with loop count, HALT and stop.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    input  logic          load_end,
    input  logic          run_start,
    input  logic [3:0]    run_loops,
    input  logic          stop,
    cu_sequencer_if.master cu,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] pc,
    output logic [PW:0]   prog_len,
    output logic          overflow
);

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [15:0]   slot_q [DEPTH];
    seq_state_t    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW:0]   len_q, len_d;
    logic [3:0]    loops_q, loops_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic          ovf_q, ovf_d;
    logic          we;
    logic [15:0]   cur;
    logic          valid, hs, last;

    assign cur   = slot_q[pc_q];
    // HALT and an empty program both leave RUN without presenting a word
    assign valid = (state_q == ST_RUN) && (len_q != '0) && (opcode_of(cur) != OP_HALT);
    assign hs    = valid && cu.cu_ready;
    assign last  = {1'b0, pc_q} == len_q - (PW+1)'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        loops_d = loops_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    len_d   = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (run_start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    loops_d = run_loops;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    len_d   = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (load_end) begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                end else if (byte_valid) begin
                    if (len_q == FULL) begin
                        ovf_d = 1'b1;
                    end else if (!phase_q) begin
                        hi_d    = byte_in;
                        phase_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        len_d   = len_q + (PW+1)'(1);
                        phase_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (!valid) begin
                    state_d = ST_DONE;
                end else if (hs) begin
                    if (!last) begin
                        pc_d = pc_q + PW'(1);
                    end else if (loops_q != 4'd0) begin
                        pc_d    = '0;
                        loops_d = loops_q - 4'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                if (stop) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            loops_q <= '0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            loops_q <= loops_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
        end
    end

    // Store is deliberately unreset; prog_len alone says which slots matter
    always_ff @(posedge clk) begin
        if (we) slot_q[len_q[PW-1:0]] <= {hi_q, byte_in};
    end

    assign cu.instr       = valid ? cur : 16'h0000;
    assign cu.instr_valid = valid;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done           = state_q == ST_DONE;
    assign pc             = pc_q;
    assign prog_len       = len_q;
    assign overflow       = ovf_q;

endmodule
